// File: rtl/miic_reg_seq.sv
// miic_reg_seq: turns one register read/write request into the START/STOP-flagged byte ops of the IIC engine
module miic_reg_seq #(
    parameter int          ADDR_BYTES = 1,
    parameter int unsigned OP_TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rnw,
    input  logic [6:0]  req_dev_addr,
    input  logic [15:0] req_reg_addr,
    input  logic [7:0]  req_wr_data,
    output logic        resp_valid,
    output logic [7:0]  resp_rd_data,
    output logic        resp_nack,
    output logic        resp_timeout,
    output logic        op_valid,
    output logic        op_start,
    output logic        op_stop,
    output logic        op_rnw,
    output logic [7:0]  op_wr_data,
    input  logic [7:0]  op_rd_data,
    input  logic        op_ack,
    input  logic        op_err,
    output logic        ops_rst
);
    typedef enum logic [3:0] {IDLE, DEVW, REGH, REGL, WDATA, DEVR, RDATA, ABORT, ERR, RESP} state_t;
    state_t state, state_nxt, seq_nxt;
    logic        rnw_q;
    logic [6:0]  dev_q;
    logic [15:0] reg_q;
    logic [7:0]  wr_q;
    logic [31:0] wdog;
    logic        accept, ack, expire, in_op, launch, rd_op, nack;

    assign accept     = req_valid && req_ready;
    assign ack        = op_valid && op_ack;
    assign expire     = op_valid && !op_ack && wdog == 32'd1;
    assign in_op      = state inside {DEVW, REGH, REGL, WDATA, DEVR, RDATA, ABORT};
    assign launch     = accept || (in_op && !op_valid);
    assign rd_op      = state inside {RDATA, ABORT};
    assign nack       = ack && op_err && !rd_op;
    assign req_ready  = state == IDLE;
    assign resp_valid = state == RESP;
    assign op_start   = state == DEVW || state == DEVR;
    assign op_stop    = state inside {WDATA, RDATA, ABORT};
    assign op_rnw     = rd_op;
    assign op_wr_data = state == DEVW  ? {dev_q, 1'b0} :
                        state == REGH  ? reg_q[15:8] :
                        state == REGL  ? reg_q[7:0] :
                        state == WDATA ? wr_q :
                        state == DEVR  ? {dev_q, 1'b1} : 8'h00;

    // State register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;

    // Next state: advance on ack, divert on NACK (WDATA already carried STOP) or watchdog expiry
    always_comb begin
        seq_nxt   = state == DEVW ? (ADDR_BYTES == 2 ? REGH : REGL) :
                    state == REGH ? REGL :
                    state == REGL ? (rnw_q ? DEVR : WDATA) :
                    state == DEVR ? RDATA : RESP;
        state_nxt = state == IDLE ? (accept ? DEVW : IDLE) :
                    state == ERR  ? RESP :
                    state == RESP ? IDLE :
                    expire        ? ERR :
                    nack          ? (state == WDATA ? RESP : ABORT) :
                    ack           ? seq_nxt : state;
    end

    // Request capture, op_valid handshake with one idle cycle between ops, watchdog and response flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnw_q        <= 1'b0;
            dev_q        <= '0;
            reg_q        <= '0;
            wr_q         <= '0;
            wdog         <= '0;
            op_valid     <= 1'b0;
            ops_rst      <= 1'b0;
            resp_rd_data <= '0;
            resp_nack    <= 1'b0;
            resp_timeout <= 1'b0;
        end else begin
            ops_rst <= expire;
            if (accept) begin
                rnw_q        <= req_rnw;
                dev_q        <= req_dev_addr;
                reg_q        <= req_reg_addr;
                wr_q         <= req_wr_data;
                resp_nack    <= 1'b0;
                resp_timeout <= 1'b0;
            end
            if (launch) begin
                op_valid <= 1'b1;
                wdog     <= OP_TIMEOUT;
            end else begin
                if (ack || expire) op_valid <= 1'b0;
                if (op_valid && !op_ack) wdog <= wdog - 32'd1;
            end
            if (nack) resp_nack <= 1'b1;
            if (expire) resp_timeout <= 1'b1;
            if (ack && state == RDATA) resp_rd_data <= op_rd_data;
        end
    end
endmodule

// File: tb/tb_miic_reg_seq.sv
// tb_miic_reg_seq: randomized scoreboard bench with a behavioural engine model for miic_reg_seq
module tb_miic_reg_seq;
    localparam int AB = 2;
    localparam int TO = 16;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_rnw = 1'b0;
    logic [6:0]  req_dev_addr = '0;
    logic [15:0] req_reg_addr = '0;
    logic [7:0]  req_wr_data = '0;
    logic        resp_valid, resp_nack, resp_timeout;
    logic [7:0]  resp_rd_data;
    logic        op_valid, op_start, op_stop, op_rnw, ops_rst;
    logic [7:0]  op_wr_data;
    logic [7:0]  op_rd_data = '0;
    logic        op_ack = 1'b0, op_err = 1'b0;

    typedef struct packed {logic s; logic p; logic r; logic [7:0] d;} op_t;
    typedef struct packed {logic [7:0] rd; logic nack; logic to;} resp_t;
    typedef struct {int dly; bit err; bit hang; bit rstw; logic [7:0] rd;} plan_t;

    op_t   exp_ops[$];
    plan_t plans[$];
    resp_t exp_resp[$];
    int n_vec = 0, n_err = 0, n_resp = 0, n_req = 0, n_to = 0, n_rst = 0, cyc = 0, mark = 0;
    logic [7:0] last_rd = 8'h00;

    miic_reg_seq #(.ADDR_BYTES(AB), .OP_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
        .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr), .req_wr_data(req_wr_data),
        .resp_valid(resp_valid), .resp_rd_data(resp_rd_data), .resp_nack(resp_nack), .resp_timeout(resp_timeout),
        .op_valid(op_valid), .op_start(op_start), .op_stop(op_stop), .op_rnw(op_rnw), .op_wr_data(op_wr_data),
        .op_rd_data(op_rd_data), .op_ack(op_ack), .op_err(op_err), .ops_rst(ops_rst)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (ops_rst) n_rst <= n_rst + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic op_t cur_op();
        return {op_start, op_stop, op_rnw, op_wr_data};
    endfunction

    function automatic logic [31:0] rst_vec();
        return 32'({req_ready, resp_valid, resp_rd_data, resp_nack, resp_timeout,
                    op_valid, op_start, op_stop, op_rnw, op_wr_data, ops_rst});
    endfunction

    // Reference model: expected op list and response from the request and the engine's behaviour plan
    task automatic issue(input bit rnw, input logic [6:0] dev, input logic [15:0] ra, input logic [7:0] wd,
                         input logic [7:0] rd, input int nk, input int to, input bit b2b);
        op_t   ops[$];
        plan_t p;
        resp_t r;
        int    n;
        r.nack = 1'b0;
        r.to   = 1'b0;
        ops.push_back(op_t'{1'b1, 1'b0, 1'b0, {dev, 1'b0}});
        if (AB == 2) ops.push_back(op_t'{1'b0, 1'b0, 1'b0, ra[15:8]});
        ops.push_back(op_t'{1'b0, 1'b0, 1'b0, ra[7:0]});
        if (rnw) begin
            ops.push_back(op_t'{1'b1, 1'b0, 1'b0, {dev, 1'b1}});
            ops.push_back(op_t'{1'b0, 1'b1, 1'b1, 8'h00});
        end else ops.push_back(op_t'{1'b0, 1'b1, 1'b0, wd});
        for (int i = 0; i < ops.size(); i++) begin
            p.dly  = int'($urandom_range(0, 5));
            p.hang = (i == to);
            p.rstw = 1'b0;
            p.rd   = rd;
            p.err  = (i == nk) || (ops[i].r && $urandom_range(0, 1) == 1);
            exp_ops.push_back(ops[i]);
            plans.push_back(p);
            if (i == to) begin
                r.to = 1'b1;
                break;
            end
            if (p.err && !ops[i].r) begin
                r.nack = 1'b1;
                if (!ops[i].p) begin
                    exp_ops.push_back(op_t'{1'b0, 1'b1, 1'b1, 8'h00});
                    p.dly  = int'($urandom_range(0, 5));
                    p.err  = 1'($urandom);
                    p.hang = 1'b0;
                    plans.push_back(p);
                end
                break;
            end
            if (ops[i].r) last_rd = rd;
        end
        r.rd = last_rd;
        exp_resp.push_back(r);
        n_to += int'(r.to);
        req_rnw      = rnw;
        req_dev_addr = dev;
        req_reg_addr = ra;
        req_wr_data  = wd;
        req_valid    = 1'b1;
        n_req++;
        n = 0;
        while (!req_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", 32'(req_ready), 32'd1);
        @(negedge clk);
        if (!b2b) begin
            req_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    // Engine model: checks each presented op, then acks after a random delay, hangs, or waits out a reset
    initial begin : engine
        op_t   e;
        plan_t p;
        int    n;
        forever begin
            @(negedge clk);
            op_ack = 1'b0;
            if (op_valid && rst_n) begin
                if (exp_ops.size() == 0 || plans.size() == 0) begin
                    chk("op_extra", 32'(exp_ops.size()), 32'd1);
                    op_ack = 1'b1;
                    op_err = 1'b0;
                    @(negedge clk);
                    op_ack = 1'b0;
                end else begin
                    e = exp_ops.pop_front();
                    p = plans.pop_front();
                    chk("op_fields", 32'({op_valid, cur_op()}), 32'({1'b1, e}));
                    if (p.hang || p.rstw) begin
                        n = 0;
                        while (op_valid && n < 200) begin
                            @(negedge clk);
                            n++;
                        end
                        if (p.hang) begin
                            chk("timeout_len", 32'(n), 32'(TO));
                            chk("ops_rst_pulse", 32'(ops_rst), 32'd1);
                            mark = cyc;
                        end
                    end else begin
                        repeat (p.dly) begin
                            @(negedge clk);
                            chk("op_hold", 32'({op_valid, cur_op()}), 32'({1'b1, e}));
                        end
                        op_ack     = 1'b1;
                        op_err     = p.err;
                        op_rd_data = p.rd;
                        mark       = cyc;
                        @(negedge clk);
                        op_ack     = 1'b0;
                        op_err     = 1'($urandom);
                        op_rd_data = 8'($urandom);
                        chk("op_gap", 32'(op_valid), 32'd0);
                    end
                end
            end else if ($urandom_range(0, 7) == 0) begin
                op_ack     = 1'b1;
                op_err     = 1'b1;
                op_rd_data = 8'($urandom);
            end
        end
    end

    // Response monitor: pops the scoreboard on every resp_valid
    initial begin : monitor
        resp_t r;
        forever begin
            @(negedge clk);
            if (resp_valid) begin
                if (exp_resp.size() == 0) chk("resp_extra", 32'(exp_resp.size()), 32'd1);
                else begin
                    r = exp_resp.pop_front();
                    chk("resp_rd_data", 32'(resp_rd_data), 32'(r.rd));
                    chk("resp_nack", 32'(resp_nack), 32'(r.nack));
                    chk("resp_timeout", 32'(resp_timeout), 32'(r.to));
                    chk("resp_latency", 32'(cyc), 32'(mark + 1));
                end
                n_resp++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, %0d responses", n_resp);
        $fatal(1);
    end

    initial begin : stim
        int n, nops, nk, to;
        bit rnw;
        repeat (3) @(negedge clk);
        chk("reset_state", rst_vec(), 32'h0100_0000);
        rst_n = 1'b1;
        @(negedge clk);
        issue(1'b0, 7'h50, 16'h0012, 8'hA5, 8'h00, -1, -1, 1'b0);
        issue(1'b1, 7'h50, 16'h0304, 8'h00, 8'h3C, -1, -1, 1'b0);
        issue(1'b0, 7'h50, 16'h0012, 8'h5A, 8'h00, 0, -1, 1'b0);
        issue(1'b0, 7'h50, 16'h0012, 8'h5A, 8'h00, AB + 1, -1, 1'b0);
        issue(1'b1, 7'h50, 16'h0304, 8'h00, 8'h77, -1, 0, 1'b0);
        issue(1'b1, 7'h21, 16'h00FF, 8'h00, 8'hC3, -1, -1, 1'b0);
        for (int k = 0; k < 40; k++) begin
            rnw  = 1'($urandom);
            nops = rnw ? AB + 3 : AB + 2;
            n    = int'($urandom_range(0, 9));
            nk   = -1;
            to   = -1;
            if (n < 2) nk = int'($urandom_range(0, nops - 1));
            if (n == 2) to = int'($urandom_range(0, nops - 1));
            issue(rnw, 7'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), nk, to,
                  k < 39 && $urandom_range(0, 1) == 1);
        end
        n = 0;
        while (exp_resp.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_before_reset", 32'(exp_resp.size()), 32'd0);
        exp_ops.push_back(op_t'{1'b1, 1'b0, 1'b0, {7'h2A, 1'b0}});
        exp_ops.push_back(op_t'{1'b0, 1'b0, 1'b0, 8'hBE});
        exp_ops.push_back(op_t'{1'b0, 1'b0, 1'b0, 8'hEF});
        plans.push_back('{dly: 1, err: 1'b0, hang: 1'b0, rstw: 1'b0, rd: 8'h00});
        plans.push_back('{dly: 1, err: 1'b0, hang: 1'b0, rstw: 1'b0, rd: 8'h00});
        plans.push_back('{dly: 0, err: 1'b0, hang: 1'b0, rstw: 1'b1, rd: 8'h00});
        req_rnw      = 1'b1;
        req_dev_addr = 7'h2A;
        req_reg_addr = 16'hBEEF;
        req_valid    = 1'b1;
        n = 0;
        while (!req_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!(exp_ops.size() == 0 && op_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reach_regl", 32'({op_valid, cur_op()}), 32'({1'b1, op_t'{1'b0, 1'b0, 1'b0, 8'hEF}}));
        #2 rst_n = 1'b0;
        #1 chk("async_reset", rst_vec(), 32'h0100_0000);
        last_rd = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 5; k++)
            issue(1'($urandom), 7'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), -1, -1, k < 4);
        n = 0;
        while ((exp_resp.size() != 0 || exp_ops.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        chk("drain_end", 32'(exp_resp.size() + exp_ops.size()), 32'd0);
        chk("resp_count", 32'(n_resp), 32'(n_req));
        chk("ops_rst_count", 32'(n_rst), 32'(n_to));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
